// File: rtl/ulpi_link_ctrl_if.sv
// ulpi_link_ctrl_if: ULPI pin bundle between the link controller and the PHY
// Signals:
//   dir     PHY -> link  bus direction, 1 = PHY drives data
//   nxt     PHY -> link  next/throttle
//   stp     link -> PHY  stop
//   data_o  link -> PHY  value the link puts on the data bus
//   data_oe link -> PHY  link output enable (already gated with dir)
//   data_i  PHY -> link  data bus as seen at the pad
// The bidirectional data bus is carried as out/enable/in so a pad buffer
// (or the bench) resolves it: pin = data_oe ? data_o : PHY drive.
interface ulpi_link_ctrl_if;
    logic       dir;
    logic       nxt;
    logic       stp;
    logic [7:0] data_o;
    logic       data_oe;
    logic [7:0] data_i;
    modport master (input dir, nxt, data_i, output stp, data_o, data_oe);
    modport slave  (output dir, nxt, data_i, input stp, data_o, data_oe);
endinterface

// File: rtl/ulpi_link_ctrl.sv
// ulpi_link_ctrl: ULPI link-side controller (TX packets, RX stream and RXCMD, optional register writes)
// Ports:
//   clk, rst_n     60 MHz ULPI clock, asynchronous active-low reset
//   ulpi           ULPI pins (master side): dir, nxt, stp, data out/oe/in
//   tx_data_i      transmit byte, first byte of a packet is the PID
//   tx_valid_i     tx_data_i valid; tx_last_i marks the final byte
//   tx_ready_o     byte accepted this cycle; tx_err_o pulses when the PHY aborts a packet
//   rx_data_o      received byte, qualified by rx_valid_o (one cycle per byte)
//   rx_end_o       one-cycle pulse, receive burst ended
//   rxcmd_o        last RXCMD byte received
//   reg_req_i, reg_addr_i, reg_wdata_i, reg_ack_o  register write port
// Parameter RXCMD_RST: reset value of rxcmd_o.
// Macro ULPI_REGWR_EN: builds the register write path; when undefined the reg_*
// inputs are ignored and reg_ack_o is tied 0.
module ulpi_link_ctrl #(
    parameter logic [7:0] RXCMD_RST = 8'h00
) (
    input  logic             clk,
    input  logic             rst_n,
    ulpi_link_ctrl_if.master ulpi,
    input  logic [7:0]       tx_data_i,
    input  logic             tx_valid_i,
    input  logic             tx_last_i,
    output logic             tx_ready_o,
    output logic             tx_err_o,
    output logic [7:0]       rx_data_o,
    output logic             rx_valid_o,
    output logic             rx_end_o,
    output logic [7:0]       rxcmd_o,
    input  logic             reg_req_i,
    input  logic [5:0]       reg_addr_i,
    input  logic [7:0]       reg_wdata_i,
    output logic             reg_ack_o
);
    typedef enum logic [2:0] {
        IDLE, TXCMD, TXDATA, STP, DRAIN
`ifdef ULPI_REGWR_EN
        , REGCMD, REGDATA
`endif
    } state_t;

    state_t     state_q, state_d;
    logic       dir_q, oe_q, rxb_q, ended_q, rx_valid_q, rx_end_q;
    logic [7:0] rx_data_q, rxcmd_q, hold_q, bus_d;
    logic       stp_d, quiet, rx_cyc, end_d;

    // quiet: link owns a settled bus; rx_cyc: PHY owns a settled bus
    assign quiet  = ~ulpi.dir & ~dir_q;
    assign rx_cyc = ulpi.dir & dir_q;
    // one rx_end per burst, only once a byte has been seen
    assign end_d  = rxb_q & ~ended_q &
                    ((rx_cyc & ~ulpi.nxt & (ulpi.data_i[5:4] != 2'b01)) | (~ulpi.dir & dir_q));

    always_comb begin
        state_d    = state_q;
        bus_d      = 8'h00;
        stp_d      = 1'b0;
        tx_ready_o = 1'b0;
        tx_err_o   = 1'b0;
        case (state_q)
            IDLE: if (quiet) begin
`ifdef ULPI_REGWR_EN
                if (reg_req_i) state_d = REGCMD;
                else
`endif
                if (tx_valid_i) state_d = TXCMD;
            end
            TXCMD: begin
                bus_d = {4'b0100, tx_data_i[3:0]};
                if (ulpi.dir) state_d = IDLE;
                else if (ulpi.nxt & quiet) begin
                    tx_ready_o = 1'b1;
                    state_d    = tx_last_i ? STP : TXDATA;
                end
            end
            TXDATA: begin
                bus_d = tx_valid_i ? tx_data_i : hold_q;
                // the last byte is never accepted in the abort cycle, so drain
                if (ulpi.dir) begin
                    tx_err_o = 1'b1;
                    state_d  = DRAIN;
                end else if (ulpi.nxt & quiet) begin
                    tx_ready_o = 1'b1;
                    if (tx_last_i) state_d = STP;
                end
            end
            STP: begin
                stp_d   = 1'b1;
                state_d = IDLE;
            end
            DRAIN: begin
                tx_ready_o = tx_valid_i;
                if (tx_valid_i & tx_last_i) state_d = IDLE;
            end
`ifdef ULPI_REGWR_EN
            REGCMD: begin
                bus_d = {2'b10, reg_addr_i};
                if (ulpi.dir) state_d = IDLE;
                else if (ulpi.nxt & quiet) state_d = REGDATA;
            end
            REGDATA: begin
                bus_d = reg_wdata_i;
                if (ulpi.dir) state_d = IDLE;
                else if (ulpi.nxt & quiet) state_d = STP;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            dir_q      <= 1'b0;
            oe_q       <= 1'b0;
            rxb_q      <= 1'b0;
            ended_q    <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_end_q   <= 1'b0;
            rx_data_q  <= 8'h00;
            rxcmd_q    <= RXCMD_RST;
            hold_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            dir_q      <= ulpi.dir;
            oe_q       <= 1'b1;
            rx_valid_q <= rx_cyc & ulpi.nxt;
            rx_end_q   <= end_d;
            if (rx_cyc & ulpi.nxt) rx_data_q <= ulpi.data_i;
            if (rx_cyc & ~ulpi.nxt) rxcmd_q <= ulpi.data_i;
            if (tx_valid_i) hold_q <= tx_data_i;
            if (ulpi.dir & ~dir_q) begin
                rxb_q   <= 1'b0;
                ended_q <= 1'b0;
            end else begin
                if (rx_cyc & ulpi.nxt) rxb_q <= 1'b1;
                if (end_d) ended_q <= 1'b1;
            end
        end
    end

`ifdef ULPI_REGWR_EN
    logic reg_q;
    // marks an STP cycle that terminates a register write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) reg_q <= 1'b0;
        else reg_q <= state_q == REGDATA;
    end
    assign reg_ack_o = (state_q == STP) & reg_q;
`else
    logic unused_reg;
    assign unused_reg = &{1'b0, reg_req_i, reg_addr_i, reg_wdata_i};
    assign reg_ack_o  = 1'b0;
`endif

    assign ulpi.data_o  = bus_d;
    assign ulpi.data_oe = oe_q & ~ulpi.dir;
    assign ulpi.stp     = stp_d;
    assign rx_data_o    = rx_data_q;
    assign rx_valid_o   = rx_valid_q;
    assign rx_end_o     = rx_end_q;
    assign rxcmd_o      = rxcmd_q;
endmodule

// File: doc/ulpi_link_ctrl.md
Name: ulpi_link_ctrl

Overview:
- Link-side ULPI controller that drives the `link` modport of the ULPI interface (`clk`, `dir`, `nxt`, `stp`, `data`).
- Converts a byte-stream transmit request into ULPI TXCMD/data/STP sequences.
- Splits PHY-driven bus cycles into a received-data stream and an RXCMD status register.
- Sits between the USB protocol engine (upstream) and the ULPI PHY pins (downstream).

Parameters:
- RXCMD_RST, 8'h00, reset value of the `rxcmd` status register.

Ports:
- `clk` in 1: ULPI 60 MHz clock, all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `dir` in 1: ULPI bus direction; 1 = PHY drives `data`.
- `nxt` in 1: ULPI next/throttle.
- `stp` out 1: ULPI stop.
- `data` inout 8: ULPI data bus.
- `tx_data` in 8: transmit byte; the first byte of a packet is the PID.
- `tx_valid` in 1: `tx_data` valid.
- `tx_last` in 1: current byte is the final byte of the packet.
- `tx_ready` out 1: byte accepted this cycle.
- `tx_err` out 1: one-cycle pulse, packet aborted by PHY.
- `rx_data` out 8: received USB byte.
- `rx_valid` out 1: `rx_data` valid, one cycle per byte.
- `rx_end` out 1: one-cycle pulse, receive ended.
- `rxcmd` out 8: last RXCMD byte received.
- `reg_req` in 1: register write request (optional feature).
- `reg_addr` in 6: register address.
- `reg_wdata` in 8: register write data.
- `reg_ack` out 1: one-cycle pulse, register write completed.

Behaviour:
- Reset values: `stp`=0, `data` undriven, `tx_ready`=0, `tx_err`=0, `rx_valid`=0, `rx_end`=0, `rx_data`=0, `rxcmd`=RXCMD_RST, `reg_ack`=0, FSM=IDLE.
- Bus drive: `data` driven only when the link output enable is 1 AND `dir`=0.
  - The gating on `dir` is combinational, so the link releases the bus in the same cycle `dir` rises.
  - When the enable is 0, `data` is 'z'. In IDLE the link drives 8'h00.
- Turnaround:
  - `dir_q` is `dir` registered.
  - A cycle where `dir`≠`dir_q` is a turnaround cycle; the bus is ignored for RX and TX in that cycle.
- RX, cycles with `dir`=1 and `dir_q`=1:
  - `nxt`=1: `rx_data`←`data`, `rx_valid`=1 next cycle (registered, latency 1).
  - `nxt`=0: `rxcmd`←`data`.
  - `rx_end` pulses for one cycle when:
    - a captured RXCMD has bits[5:4]≠2'b01 after at least one `rx_valid` in the current RX burst, or
    - `dir` falls after at least one `rx_valid`.
  - At most one `rx_end` per burst.
- FSM transitions:
  - IDLE: if `dir`=0 and `dir_q`=0:
    - `reg_req` (feature enabled) → REGCMD. `reg_req` has priority over `tx_valid`.
    - else `tx_valid` → TXCMD.
  - TXCMD:
    - drive {4'b0100, `tx_data`[3:0]}.
    - On `nxt`=1: `tx_ready`=1 (PID consumed) → TXDATA, or → STP if `tx_last`.
  - TXDATA:
    - drive `tx_data`; `tx_ready`=`nxt`.
    - On `nxt`=1 with `tx_last` → STP.
    - If `tx_valid`=0 the link holds the previous byte (underrun is a protocol error and is not checked).
  - STP: drive 8'h00, `stp`=1 for exactly one cycle → IDLE.
  - REGCMD: drive {2'b10, `reg_addr`}; on `nxt` → REGDATA.
  - REGDATA: drive `reg_wdata`; on `nxt` → STP. `reg_ack` pulses in the STP cycle.
  - DRAIN: `tx_ready`=`tx_valid`; discard bytes until `tx_last` is accepted → IDLE.
- PHY preemption (`dir` rises) in a non-IDLE state:
  - TXCMD or REGCMD: abort with nothing consumed → IDLE; retry once `dir`=0 and `dir_q`=0.
  - TXDATA: `tx_err` pulse; → DRAIN if the last byte was not yet accepted, else IDLE.
  - STP: the STP cycle completes; the PHY owns the bus.
- Asynchronous reset mid-operation: all outputs go to reset values immediately and the bus is released. The pending packet is lost; no `tx_err` is issued.

Optional Feature:
- Macro: ULPI_REGWR_EN.
- Defined: register writes per REGCMD/REGDATA as above.
- Undefined:
  - REGCMD/REGDATA are not built.
  - `reg_req`, `reg_addr` and `reg_wdata` are ignored.
  - `reg_ack` is tied 0.
  - `tx_valid` alone starts transmission.

Test Plan:
- TX, 3-byte packet {0xC3, 0x11, 0x22}, PHY asserts `nxt` on the 2nd cycle of each byte:
  - required bus sequence: 0x43, 0x11, 0x22, then 0x00 with `stp`=1 for 1 cycle;
  - `tx_ready` pulses 3 times; `tx_err`=0.
- RX, `dir` rises, then turnaround, then RXCMD 0x1E (`nxt`=0), then bytes 0xA5, 0x5A (`nxt`=1), then RXCMD 0x0E, then `dir` falls:
  - link data enable drops the same cycle `dir` rises;
  - `rx_valid`×2 with `rx_data` 0xA5, 0x5A;
  - `rxcmd` ends at 0x0E;
  - exactly one `rx_end`.
- Preemption during TXCMD (`dir` rises before `nxt`):
  - `tx_ready` stays 0, no `tx_err`;
  - after `dir` falls plus one turnaround cycle, TXCMD 0x43 is reissued.
- Preemption during TXDATA after 2 of 4 bytes are accepted:
  - `tx_err` 1-cycle pulse;
  - remaining 2 bytes drained via `tx_ready` without being driven;
  - FSM returns to IDLE.
- With ULPI_REGWR_EN, `reg_req` and `tx_valid` both high in IDLE, `reg_addr`=0x0A, `reg_wdata`=0x55:
  - bus shows 0x8A, 0x55, `stp`;
  - `reg_ack` pulses once; the TX packet starts afterwards.
  - Without the macro: `reg_ack` stays 0 and the TX packet starts first.
- Assert `rst_n`=0 mid-TXDATA:
  - `stp`=0 and bus undriven immediately;
  - `rxcmd`=RXCMD_RST; FSM in IDLE after release.
